// File: rtl/axis_wait_pkg.sv
// axis_wait_pkg: shared FSM encoding and width helper
// for the AXI-Stream store-and-forward delay stage.
package axis_wait_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RECV = S_RECV,
    WAIT = S_WAIT,
    SEND = S_SEND
  } state_e;

  // Smallest r with 2**r >= n (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/axis_wait_buffer_if.sv
// axis_wait_buffer_if: one AXI-Stream link.
// Signals: tdata, tvalid, tlast (master->slave), tready (slave->master).
interface axis_wait_buffer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/axis_wait_buffer_mem.sv
// axis_wait_buffer_mem: DATA_WIDTH x DEPTH packet store.
// Ports: clk, we_i/waddr_i/wdata_i (sync write), raddr_i/rdata_o (comb read).
module axis_wait_buffer_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AW         = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_wait_buffer.sv
// axis_wait_buffer: capture one AXIS packet, idle wait_cycles, replay it.
// Ports: clk, rst (sync, active-low), ex_start/wait_cycles/start_ack,
//        busy, truncated, pkt_len, s_axis (slave), m_axis (master).
module axis_wait_buffer
  import axis_wait_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 16,
  parameter  int WAIT_WIDTH = 16,
  localparam int PW         = clog2(DEPTH),
  localparam int LW         = clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_start,
  input  logic [WAIT_WIDTH-1:0] wait_cycles,
  output logic                  start_ack,
  output logic                  busy,
  output logic                  truncated,
  output logic [LW-1:0]         pkt_len,
  axis_wait_buffer_if.slave     s_axis,
  axis_wait_buffer_if.master    m_axis
);

  state_e                state_q;
  logic [WAIT_WIDTH-1:0] wait_reg_q;
  logic [WAIT_WIDTH-1:0] wait_cnt_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [LW-1:0]         len_q;
  logic                  trunc_q;
  logic                  ack_q;

  logic                  in_recv;
  logic                  in_send;
  logic                  s_fire;
  logic                  m_fire;
  logic [LW-1:0]         len_inc;
  logic                  in_end;
  logic                  out_last;
  logic [DATA_WIDTH-1:0] rdata;

  assign in_recv  = (state_q == RECV);
  assign in_send  = (state_q == SEND);
  assign s_fire   = in_recv && s_axis.tvalid;
  assign m_fire   = in_send && m_axis.tready;
  assign len_inc  = len_q + LW'(1);
  // Packet closes on TLAST or on the beat that fills the store.
  assign in_end   = s_fire &&
                    (s_axis.tlast || len_inc == LW'(DEPTH));
  assign out_last = (LW'(rd_ptr_q) == len_q - LW'(1));

  axis_wait_buffer_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (PW)
  ) u_mem (
    .clk     (clk),
    .we_i    (s_fire),
    .waddr_i (wr_ptr_q),
    .wdata_i (s_axis.tdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      wait_reg_q <= '0;
      wait_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      len_q      <= '0;
      trunc_q    <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (ex_start) begin
            wait_reg_q <= wait_cycles;
            len_q      <= '0;
            wr_ptr_q   <= '0;
            trunc_q    <= 1'b0;
            ack_q      <= 1'b1;
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (s_fire) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
            len_q    <= len_inc;
          end
          if (in_end) begin
            trunc_q  <= !s_axis.tlast;
            rd_ptr_q <= '0;
            if (wait_reg_q != '0) begin
              wait_cnt_q <= wait_reg_q;
              state_q    <= WAIT;
            end else begin
              state_q    <= SEND;
            end
          end
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q - WAIT_WIDTH'(1);
          if (wait_cnt_q == WAIT_WIDTH'(1))
            state_q <= SEND;
        end
        SEND: begin
          if (m_fire) begin
            if (out_last) begin
              rd_ptr_q <= '0;
              state_q  <= IDLE;
            end else begin
              rd_ptr_q <= rd_ptr_q + PW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start_ack     = ack_q;
  assign busy          = (state_q != IDLE);
  assign truncated     = trunc_q;
  assign pkt_len       = len_q;
  assign s_axis.tready = in_recv;
  assign m_axis.tvalid = in_send;
  assign m_axis.tdata  = in_send ? rdata : '0;
  assign m_axis.tlast  = in_send && out_last;

endmodule

// File: tb/tb_axis_wait_buffer.sv
// tb_axis_wait_buffer: vector table plus scoreboard for axis_wait_buffer.
// Output beats are checked in order against a queue filled by the driver.
module tb_axis_wait_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int WW    = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_start = 1'b0;
  logic [WW-1:0] wait_cycles = '0;
  logic          start_ack;
  logic          busy;
  logic          truncated;
  logic [LW-1:0] pkt_len;

  axis_wait_buffer_if #(.DATA_WIDTH(DW)) s_if ();
  axis_wait_buffer_if #(.DATA_WIDTH(DW)) m_if ();

  axis_wait_buffer #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .WAIT_WIDTH (WW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_start    (ex_start),
    .wait_cycles (wait_cycles),
    .start_ack   (start_ack),
    .busy        (busy),
    .truncated   (truncated),
    .pkt_len     (pkt_len),
    .s_axis      (s_if),
    .m_axis      (m_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    int          nbeats;
    bit          has_last;
    int          wcyc;
    logic [31:0] base;
    logic [7:0]  pat;
    int          exp_len;
    bit          exp_trunc;
  } vec_t;

  exp_t sb[$];

  int          tests    = 0;
  int          fails    = 0;
  int          ack_cnt  = 0;
  int          first_tv = -1;
  int          last_hs  = -1;
  logic [7:0]  m_pat    = 8'hFF;
  logic [2:0]  pat_i    = '0;
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [DW-1:0] pd = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic out_zero(input string tag);
    chk({tag, "_start_ack"}, 64'(start_ack), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_truncated"}, 64'(truncated), 0);
    chk({tag, "_pkt_len"}, 64'(pkt_len), 0);
    chk({tag, "_s_tready"}, 64'(s_if.tready), 0);
    chk({tag, "_m_tvalid"}, 64'(m_if.tvalid), 0);
    chk({tag, "_m_tlast"}, 64'(m_if.tlast), 0);
    chk({tag, "_m_tdata"}, 64'(m_if.tdata), 0);
  endtask

  // Output side: drives m_tready from the pattern, checks beats and stalls.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      m_if.tready = m_pat[pat_i];
      pat_i = pat_i + 3'd1;
      if (rst) begin
        if (start_ack) ack_cnt++;
        if (m_if.tvalid && first_tv < 0) first_tv = cyc;
        if (pv && !pr) begin
          chk("stall_valid", 64'(m_if.tvalid), 1);
          chk("stall_data", 64'(m_if.tdata), 64'(pd));
          chk("stall_last", 64'(m_if.tlast), 64'(pl));
        end
        if (m_if.tvalid && m_if.tready) begin
          chk("beat_expected", 64'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("m_tdata", 64'(m_if.tdata), 64'(e.d));
            chk("m_tlast", 64'(m_if.tlast), 64'(e.l));
          end
          last_hs = cyc;
        end
      end
      pv = m_if.tvalid;
      pr = m_if.tready;
      pd = m_if.tdata;
      pl = m_if.tlast;
    end
  end

  // Entered at the negedge of the first RECV cycle.
  task automatic core(input vec_t v);
    exp_t e;
    int idx, acc, last_acc, n;
    chk("start_ack", 64'(start_ack), 1);
    chk("busy_recv", 64'(busy), 1);
    chk("trunc_clear", 64'(truncated), 0);
    chk("len_clear", 64'(pkt_len), 0);
    for (int i = 0; i < v.exp_len; i++) begin
      e.d = v.base + 32'(i);
      e.l = (i == v.exp_len - 1);
      sb.push_back(e);
    end
    idx = 0;
    acc = 0;
    last_acc = -1;
    while (idx < v.nbeats) begin
      s_if.tvalid = 1'b1;
      s_if.tdata  = v.base + 32'(idx);
      s_if.tlast  = v.has_last && (idx == v.nbeats - 1);
      if (!s_if.tready) break;
      acc++;
      last_acc = cyc;
      idx++;
      @(negedge clk);
    end
    chk("s_tready_drop", 64'(s_if.tready), 0);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    chk("accepted", 64'(acc), 64'(v.exp_len));
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("done_in_time", 64'(busy), 0);
    chk("busy_drop", 64'(cyc - last_hs), 1);
    chk("latency", 64'(first_tv - last_acc), 64'(1 + v.wcyc));
    chk("pkt_len", 64'(pkt_len), 64'(v.exp_len));
    chk("truncated", 64'(truncated), 64'(v.exp_trunc));
    chk("sb_drained", 64'(sb.size()), 0);
    chk("m_tvalid_idle", 64'(m_if.tvalid), 0);
  endtask

  task automatic run_pkt(input vec_t v);
    ack_cnt     = 0;
    first_tv    = -1;
    m_pat       = v.pat;
    ex_start    = 1'b1;
    wait_cycles = WW'(v.wcyc);
    @(negedge clk);
    ex_start = 1'b0;
    core(v);
    chk("one_ack", 64'(ack_cnt), 1);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t h1, h2, r1;
    vecs[0] = '{4,  1'b1, 3, 32'hA0,  8'hFF, 4,  1'b0};
    vecs[1] = '{1,  1'b1, 0, 32'h55,  8'hFF, 1,  1'b0};
    vecs[2] = '{20, 1'b0, 2, 32'h100, 8'hFF, 16, 1'b1};
    vecs[3] = '{6,  1'b1, 1, 32'hB0,  8'h29, 6,  1'b0};
    vecs[4] = '{16, 1'b1, 0, 32'hC0,  8'hFF, 16, 1'b0};
    vecs[5] = '{3,  1'b1, 5, 32'hD0,  8'h55, 3,  1'b0};
    h1      = '{3,  1'b1, 2, 32'h300, 8'hFF, 3,  1'b0};
    h2      = '{2,  1'b1, 0, 32'h310, 8'hFF, 2,  1'b0};
    r1      = '{3,  1'b1, 1, 32'hE8,  8'hFF, 3,  1'b0};

    s_if.tdata  = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    m_if.tready = 1'b0;

    repeat (2) @(negedge clk);
    out_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_pkt(vecs[i]);

    // ex_start held high across a whole packet.
    m_pat       = 8'hFF;
    ack_cnt     = 0;
    first_tv    = -1;
    ex_start    = 1'b1;
    wait_cycles = WW'(h1.wcyc);
    @(negedge clk);
    core(h1);
    chk("hold_single_ack", 64'(ack_cnt), 1);
    first_tv    = -1;
    wait_cycles = WW'(h2.wcyc);
    @(negedge clk);
    ex_start = 1'b0;
    core(h2);
    chk("hold_second_ack", 64'(ack_cnt), 2);

    // Reset in the middle of WAIT abandons the packet.
    ex_start    = 1'b1;
    wait_cycles = WW'(10);
    @(negedge clk);
    ex_start    = 1'b0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = 32'hE0;
    s_if.tlast  = 1'b0;
    @(negedge clk);
    s_if.tdata  = 32'hE1;
    s_if.tlast  = 1'b1;
    @(negedge clk);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(busy), 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    out_zero("midrst");
    sb.delete();
    run_pkt(r1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_wait_buffer.md
Name: axis_wait_buffer

Overview:
Parametrised AXI-Stream store-and-forward delay stage.
- On a start request it captures one packet (up to DEPTH beats, terminated by TLAST or by the buffer filling) into an internal buffer.
- It then idles for a programmable number of cycles and replays the packet on an AXIS master port, regenerating TLAST.
- It sits between CNN pipeline stages as a timing/alignment buffer under control of the accelerator sequencer.

Parameters:
DATA_WIDTH, 32, width of tdata on both ports
DEPTH, 16, maximum beats per packet (>=2, power of two not required)
WAIT_WIDTH, 16, width of the programmable wait count

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (0 = reset)
ex_start  in  1  request to capture one packet; sampled only in IDLE
wait_cycles  in  WAIT_WIDTH  delay between capture end and replay; sampled with ex_start
start_ack  out  1  one-cycle pulse acknowledging ex_start
busy  out  1  high whenever state != IDLE
truncated  out  1  sticky: the last packet filled DEPTH without TLAST; cleared on next accepted ex_start
pkt_len  out  clog2(DEPTH+1)  beats captured in the current/last packet
s_axis_tdata  in  DATA_WIDTH  slave data
s_axis_tvalid  in  1  slave valid
s_axis_tlast  in  1  slave last
s_axis_tready  out  1  slave ready
m_axis_tdata  out  DATA_WIDTH  master data
m_axis_tvalid  out  1  master valid
m_axis_tlast  out  1  master last
m_axis_tready  in  1  master ready

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - start_ack, busy, truncated, s_axis_tready, m_axis_tvalid and m_axis_tlast all go to 0.
  - pkt_len, the pointers and the wait counter go to 0.
  - m_axis_tdata reads 0.
  - Buffer contents are not cleared.
  - Reset mid-packet abandons the packet silently.
- FSM states: IDLE, RECV, WAIT, SEND. All outputs except m_axis_tdata/tlast are decoded from registered state/flags.
- IDLE:
  - When ex_start=1: latch wait_cycles into wait_reg, clear pkt_len/wr_ptr/truncated, move to RECV.
  - start_ack is high for exactly the first RECV cycle.
- RECV:
  - s_axis_tready = 1. A beat is accepted when tvalid&tready: mem[wr_ptr] <= tdata, wr_ptr++ and pkt_len++.
  - The packet ends on the accepted beat with tlast=1, or on the accepted beat that makes pkt_len==DEPTH. In the latter case without tlast, truncated <= 1.
  - At packet end, s_axis_tready drops in the next cycle. There are no bubbles and no extra accept.
  - At packet end the next state is WAIT with wait_cnt <= wait_reg if wait_reg != 0, otherwise SEND.
- WAIT:
  - wait_cnt decrements each cycle.
  - When wait_cnt==1 the next state is SEND.
  - The state lasts exactly wait_reg cycles.
- Latency: if the last input beat is accepted in cycle k, m_axis_tvalid first rises in cycle k+1+wait_reg.
- SEND:
  - m_axis_tvalid = 1, m_axis_tdata = mem[rd_ptr], m_axis_tlast = (rd_ptr == pkt_len-1).
  - On tvalid&tready: rd_ptr++. On the handshake with tlast: next state IDLE, rd_ptr <= 0.
  - tdata/tlast hold stable while tvalid=1 and tready=0 (AXIS rule).
- Outside SEND, m_axis_tdata = 0 and m_axis_tlast = 0.
- ex_start outside IDLE is ignored. No queueing and no ack.
- A single-beat packet (tlast on the first beat) gives pkt_len=1 and one output beat with tlast=1.
- s_axis_tready is 0 in IDLE, WAIT and SEND. Input backpressure is applied; no data is dropped except beats after a truncation, which are not accepted by this packet.
- Width rules:
  - Pointers are clog2(DEPTH) bits wide. pkt_len is clog2(DEPTH+1) bits wide so that DEPTH fits.
  - Pointers never wrap inside a packet.

Decomposition:
- Shared package axis_wait_pkg:
  - State encoding localparams (IDLE=0, RECV=1, WAIT=2, SEND=3, 2-bit).
  - A clog2 function for pointer and length widths.
- One sub-module: axis_wait_buffer_mem.
  - DATA_WIDTH x DEPTH register array.
  - One synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
  - No reset on storage.
- The FSM, counters and flags stay in the top module.

Test Plan:
- wait_cycles=3, ex_start pulse, 4 beats 0xA0..0xA3 (tlast on 0xA3), m_tready=1 -> start_ack one cycle; output 0xA0..0xA3 with tlast only on 0xA3; first m_tvalid exactly 4 cycles after the last input accept; busy drops the cycle after the last output handshake.
- wait_cycles=0, single beat 0x55 with tlast -> pkt_len=1; m_tvalid in the cycle right after the accept; tlast=1; return to IDLE.
- DEPTH=16, 20 beats offered with no tlast -> exactly 16 accepted; s_tready low from the next cycle; truncated=1; output 16 beats with tlast on the 16th; the next ex_start clears truncated.
- Random m_tready toggling (e.g. 1,0,0,1,0,1) during SEND -> tdata/tlast stable across stalls; every beat delivered in order, none duplicated.
- ex_start held high through RECV/WAIT/SEND -> no second start_ack until after IDLE is re-entered; the second packet is captured correctly.
- rst=0 for one cycle mid-WAIT (then ex_start) -> all outputs 0 in the cycle after reset; the new packet is captured and replayed with pkt_len counting from 0.
